// File: rtl/qspi_rd_sched.sv
// Two-requester round-robin read scheduler for the QSPI flash pads: issues single-lane
// SPI READ (0x03 + 24-bit address) and returns each received byte as an ID-tagged pulse.
module qspi_rd_sched #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned CS_GAP  = 4,
  parameter int unsigned LEN_W   = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             req0_valid,
  input  logic [23:0]      req0_addr,
  input  logic [LEN_W-1:0] req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [23:0]      req1_addr,
  input  logic [LEN_W-1:0] req1_len,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [7:0]       rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic             qspi_sck_o,
  output logic             qspi_cs_o,
  output logic             qspi_dq0_o,
  output logic             qspi_dq0_oe,
  input  logic             qspi_dq1_i
);

  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GAP_W    = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
  localparam int unsigned GAP_LAST = (CS_GAP > 1) ? CS_GAP - 2 : 0;
  localparam logic [7:0]  OPC_READ = 8'h03;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DATA, S_GAP} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [5:0]       r_bit;
  logic [LEN_W-1:0] r_byte;
  logic [LEN_W-1:0] r_len;
  logic [31:0]      r_tx;
  logic [7:0]       r_rx;
  logic [GAP_W-1:0] r_gap;
  logic             r_id;
  logic             r_last_gnt;
  logic             r_pend;
  logic             r_pend_last;

  logic w_sel;
  logic w_idle;
  logic w_gnt;
  logic w_active;
  logic w_tick;
  logic w_rise;
  logic w_fall;

  // Tie goes to the requester not granted last; a lone valid requester always wins.
  assign w_sel      = (req0_valid && req1_valid) ? ~r_last_gnt : req1_valid;
  assign w_idle     = (r_state == S_IDLE) && !sys_rst;
  assign req0_ready = w_idle && req0_valid && !w_sel;
  assign req1_ready = w_idle && req1_valid && w_sel;
  assign w_gnt      = req0_ready || req1_ready;

  assign w_active = (r_state == S_CMD) || (r_state == S_ADDR) || (r_state == S_DATA);
  assign w_tick   = w_active && (r_div == DIV_W'(CLK_DIV - 1));
  assign w_rise   = w_tick && !qspi_sck_o;
  assign w_fall   = w_tick && qspi_sck_o;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_bit       <= '0;
      r_byte      <= '0;
      r_len       <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_gap       <= '0;
      r_id        <= 1'b0;
      r_last_gnt  <= 1'b1;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
      rsp_last    <= 1'b0;
      busy        <= 1'b0;
      qspi_sck_o  <= 1'b0;
      qspi_cs_o   <= 1'b1;
      qspi_dq0_o  <= 1'b0;
      qspi_dq0_oe <= 1'b0;
    end else begin
      // A completed byte is presented one cycle after its last sampling edge.
      r_pend    <= 1'b0;
      rsp_valid <= r_pend;
      if (r_pend) begin
        rsp_data <= r_rx;
        rsp_last <= r_pend_last;
        rsp_id   <= r_id;
      end

      if (w_active) begin
        r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      end
      if (w_tick) begin
        qspi_sck_o <= ~qspi_sck_o;
      end

      case (r_state)
        S_IDLE: begin
          if (w_gnt) begin
            r_state     <= S_CMD;
            busy        <= 1'b1;
            r_id        <= w_sel;
            r_last_gnt  <= w_sel;
            r_len       <= w_sel ? req1_len : req0_len;
            r_tx        <= {OPC_READ, (w_sel ? req1_addr : req0_addr)};
            qspi_dq0_o  <= OPC_READ[7];
            qspi_dq0_oe <= 1'b1;
            qspi_cs_o   <= 1'b0;
            r_div       <= '0;
            r_bit       <= '0;
            r_byte      <= '0;
          end
        end
        S_CMD, S_ADDR: begin
          if (w_fall) begin
            r_tx  <= {r_tx[30:0], 1'b0};
            r_bit <= r_bit + 6'd1;
            if (r_bit == 6'd7) begin
              r_state <= S_ADDR;
            end
            if (r_bit == 6'd31) begin
              r_state     <= S_DATA;
              r_bit       <= '0;
              qspi_dq0_o  <= 1'b0;
              qspi_dq0_oe <= 1'b0;
            end else begin
              qspi_dq0_o <= r_tx[30];
            end
          end
        end
        S_DATA: begin
          if (w_rise) begin
            r_rx <= {r_rx[6:0], qspi_dq1_i};
            if (r_bit == 6'd7) begin
              r_pend      <= 1'b1;
              r_pend_last <= (r_byte == r_len);
            end
          end
          // The falling edge after the final data bit closes the transaction.
          if (w_fall) begin
            if (r_bit != 6'd7) begin
              r_bit <= r_bit + 6'd1;
            end else if (r_byte != r_len) begin
              r_bit  <= '0;
              r_byte <= r_byte + LEN_W'(1);
            end else begin
              qspi_cs_o  <= 1'b1;
              qspi_sck_o <= 1'b0;
              r_div      <= '0;
              r_gap      <= '0;
              if (CS_GAP > 1) begin
                r_state <= S_GAP;
              end else begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
              end
            end
          end
        end
        S_GAP: begin
          // The IDLE cycle that follows counts as the last CS-high cycle.
          if (r_gap == GAP_W'(GAP_LAST)) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_gap <= r_gap + GAP_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
